// File: rtl/fifo_uart_tx.sv
// Drains the 16x8 FIFO one byte at a time and serialises each byte as 8N1 on TxD.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = 16
) (
  input  logic       ck,
  input  logic       rst,
  input  logic       Enable,
  input  logic       Fempty,
  input  logic [7:0] Fdata,
  output logic       Ren,
  output logic       TxD,
  output logic       Busy,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
`ifdef FIFO_UART_TX_PARITY_EN
    PAR   = 3'd5,
`endif
    STOP  = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_n;
  logic [7:0]       shift, shift_n;
  logic             ren_n, txd_n, busy_n;
  logic             bit_end;
`ifdef FIFO_UART_TX_PARITY_EN
  logic             par, par_n;
`endif

  assign state_dbg = state;
  assign bit_end   = (cnt == LAST);

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      Ren     <= 1'b0;
      TxD     <= 1'b1;
      Busy    <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      shift   <= shift_n;
      Ren     <= ren_n;
      TxD     <= txd_n;
      Busy    <= busy_n;
`ifdef FIFO_UART_TX_PARITY_EN
      par     <= par_n;
`endif
    end
  end

  // Next-state and next-output logic; every output is registered above.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    shift_n = shift;
    ren_n   = 1'b0;
    txd_n   = TxD;
    busy_n  = Busy;
`ifdef FIFO_UART_TX_PARITY_EN
    par_n   = par;
`endif
    case (state)
      IDLE: begin
        txd_n  = 1'b1;
        busy_n = 1'b0;
        if (Enable && !Fempty) begin
          state_n = REQ;
          ren_n   = 1'b1;
          busy_n  = 1'b1;
        end
      end
      REQ: begin
        state_n = WAIT;
      end
      WAIT: begin
        // Fdata reflects the pop issued during REQ.
        shift_n = Fdata;
`ifdef FIFO_UART_TX_PARITY_EN
        par_n   = ^Fdata;
`endif
        txd_n   = 1'b0;
        cnt_n   = '0;
        bit_n   = '0;
        state_n = START;
      end
      START: begin
        if (bit_end) begin
          cnt_n   = '0;
          txd_n   = shift[0];
          state_n = DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_n   = '0;
          shift_n = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) begin
            bit_n = '0;
`ifdef FIFO_UART_TX_PARITY_EN
            txd_n   = par;
            state_n = PAR;
`else
            txd_n   = 1'b1;
            state_n = STOP;
`endif
          end else begin
            bit_n = bit_idx + 3'd1;
            txd_n = shift[1];
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PAR: begin
        if (bit_end) begin
          cnt_n   = '0;
          txd_n   = 1'b1;
          state_n = STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          cnt_n   = '0;
          busy_n  = 1'b0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        txd_n   = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Read-side consumer for the team's 16x8 FIFO. It pops one byte at a time through the FIFO's Ren/Dout/Fempty interface and serialises each byte onto a single line as an asynchronous serial frame:
- 1 start bit, 8 data bits LSB first, 1 stop bit, line idle high.

It sits between the FIFO's Dout port and the chip-level TxD pin, and is the draining end for whatever block writes the FIFO.

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit; legal range 2..65535.
CNT_W, 16, width of the bit-period counter; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
ck  input  1  system clock; all state changes on the rising edge
rst  input  1  asynchronous, active-high reset
Enable  input  1  when high, block may start popping new bytes
Fempty  input  1  FIFO empty flag (registered in the FIFO)
Fdata  input  8  FIFO Dout; valid in the cycle after the edge that samples Ren=1
Ren  output  1  FIFO read strobe; a registered single-cycle pulse
TxD  output  1  serial line, idle high
Busy  output  1  high from REQ through the end of the stop bit (or parity+stop)

Behaviour:
- Reset (async, immediate, any state): state=IDLE, Ren=0, TxD=1, Busy=0, counters=0, shift register=0.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- States: IDLE, REQ, WAIT, START, DATA, [PAR], STOP.

State transitions:
- IDLE: if Enable=1 and Fempty=0 at an edge -> REQ, Ren=1, Busy=1. Otherwise stay, with TxD=1 and Busy=0.
- REQ: exactly one cycle with Ren=1. The FIFO samples Ren and updates Dout at the edge ending REQ. -> WAIT, Ren=0.
- WAIT: one cycle; Fdata is valid. At the edge ending WAIT, load Fdata into the shift register, drive TxD=0, clear the bit counter -> START.
- START: hold TxD=0 for CLKS_PER_BIT cycles -> DATA, TxD=shift[0].
- DATA: each bit is held CLKS_PER_BIT cycles, then shift right by one. After the 8th bit -> STOP (TxD=1), or PAR when the feature is compiled in.
- STOP: hold TxD=1 for CLKS_PER_BIT cycles -> IDLE, Busy=0.

Timing:
- Ren is never asserted for two consecutive cycles.
- Ren is never asserted outside REQ.
- Byte-to-byte Ren period under continuous supply is 10*CLKS_PER_BIT+3 cycles (11*CLKS_PER_BIT+3 with parity).
- The minimum idle-high gap between frames is therefore CLKS_PER_BIT+3 cycles, counting the stop bit.

Boundary conditions:
- Fempty is sampled only in IDLE. Fempty changes during a frame have no effect.
- Enable is sampled only in IDLE. Deasserting Enable mid-frame lets the current frame complete; no further Ren is issued.
- Fempty=1 forever: Ren stays 0 and TxD stays 1 indefinitely.
- Reset in REQ or WAIT: a byte may already have been popped from the FIFO. That byte is discarded. This is intended behaviour; upstream must flush the FIFO on reset too.
- Reset mid-frame: TxD returns to 1 asynchronously. The receiver sees a truncated frame.
- The bit-period counter counts 0..CLKS_PER_BIT-1 and wraps. The bit index counts 0..7. No other wrap conditions exist.

Optional Feature:
Macro FIFO_UART_TX_PARITY_EN.
- Defined: a PAR state is inserted between DATA and STOP. TxD carries even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles. The frame is 11 bits.
- Undefined: there is no PAR state and no parity logic. The frame is 10 bits.

Test Plan:
1. CLKS_PER_BIT=4; FIFO holds 0xA5; Enable=1 -> exactly one Ren pulse. TxD goes low 2 cycles after Ren rises. TxD sequence, 4 cycles each: 0,1,0,1,0,0,1,0,1,1. Busy falls after the stop bit. No second Ren is issued once Fempty=1.
2. CLKS_PER_BIT=4; FIFO holds 0x00, 0xFF, 0x3C -> Ren rising edges are 43 cycles apart. Frames decode to 0x00, 0xFF, 0x3C in order. The FIFO ends empty.
3. Fempty=1 and Enable=1 for 200 cycles -> Ren=0, TxD=1 and Busy=0 throughout.
4. CLKS_PER_BIT=4; Enable falls during DATA of the first of two queued bytes -> the first frame completes. No further Ren is issued; the second byte remains in the FIFO. Re-raising Enable sends it.
5. Reset pulsed while DATA bit 3 is on the line -> TxD=1, Busy=0, Ren=0 within the same cycle, with no clock edge needed. After release, the next queued byte is sent as a complete frame.
6. With FIFO_UART_TX_PARITY_EN and byte 0x07 -> the parity bit is 1 and the frame is 11 bits. With byte 0x03 -> the parity bit is 0. Ren period is 47 cycles at CLKS_PER_BIT=4.
